seg7_display_ctrl: RTL and testbench

//  Consumer of the 0x6002 write strobe from the memory/IO address decoder. Latches the
//  16-bit word the CPU writes and shows it as 4 hex digits on the Basys3 common-anode
//  7-segment display. Time-multiplexes the digits with a prescaled refresh scan.

---
 rtl/seg7_display_ctrl_if.sv | 33 +++
 rtl/seg7_display_ctrl.sv | 96 +++++++++
 tb/tb_seg7_display_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seg7_display_ctrl_if.sv
// rtl/seg7_display_ctrl_if.sv - CPU write port and display pins of the 7-segment controller
//
// Purpose: bundles the memory-mapped write strobe/data from the address decoder
//          together with the active-low display drive pins.
// Signals:
//   seg_we      CPU -> ctrl  write strobe, one clk per write
//   io_data_in  CPU -> ctrl  16-bit write data
//   seg         ctrl -> pins cathodes, active-low, {g,f,e,d,c,b,a}
//   dp          ctrl -> pins decimal point, active-low
//   an          ctrl -> pins anodes, active-low, an[0] = rightmost digit
interface seg7_display_ctrl_if;
  logic        seg_we;
  logic [15:0] io_data_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  modport master (
    output seg_we,
    output io_data_in,
    input  seg,
    input  dp,
    input  an
  );

  modport slave (
    input  seg_we,
    input  io_data_in,
    output seg,
    output dp,
    output an
  );
endinterface

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - write-only 16-bit hex display on a 4-digit common-anode 7-seg
//
// Purpose: latches the word written by the CPU and scans it out as four hex
//          digits, one digit slot every REFRESH_DIV clocks.
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   slave side of seg7_display_ctrl_if (seg_we/io_data_in in; seg/dp/an out)
module seg7_display_ctrl #(
  parameter int REFRESH_DIV        = 100000,
  parameter int LEADING_ZERO_BLANK = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_display_ctrl_if.slave   bus
);

  localparam int              PW        = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [15:0]   r_value;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_dp;

  logic [3:0]    w_nibble;
  logic [15:0]   w_upper;
  logic          w_blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_nibble = r_value[{r_digit, 2'b00} +: 4];

  // Nibbles from the active digit upward; if all zero the digit is a leading zero.
  assign w_upper  = r_value >> {r_digit, 2'b00};
  assign w_blank  = (LEADING_ZERO_BLANK != 0) && (r_digit != 2'd0) && (w_upper == 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= 16'h0000;
      r_presc <= '0;
      r_digit <= 2'd0;
      r_an    <= 4'b1111;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
    end else begin
      if (bus.seg_we) begin
        r_value <= bus.io_data_in;
      end

      // Scan phase runs free of writes.
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      // Output stage sees the pre-edge digit and value, so it trails both by one edge.
      if (w_blank) begin
        r_an  <= 4'b1111;
        r_seg <= 7'h7F;
      end else begin
        r_an  <= ~(4'b0001 << r_digit);
        r_seg <= hex7(w_nibble);
      end
      r_dp <= 1'b1;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - self-checking bench for seg7_display_ctrl
module tb_seg7_display_ctrl;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg7_display_ctrl_if bus0 ();
  seg7_display_ctrl_if bus1 ();

  seg7_display_ctrl #(.REFRESH_DIV(DIV), .LEADING_ZERO_BLANK(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  seg7_display_ctrl #(.REFRESH_DIV(DIV), .LEADING_ZERO_BLANK(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: edges seen since reset released, and the stored word.
  int          m_edges = 0;
  logic [15:0] m_value = 16'h0000;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [15:0] d);
    rst             = r;
    bus0.seg_we     = we;
    bus1.seg_we     = we;
    bus0.io_data_in = d;
    bus1.io_data_in = d;
  endtask

  // One clock: apply inputs, predict outputs from the state before the edge,
  // advance the model, then compare just after the edge.
  task automatic step(input logic r, input logic we, input logic [15:0] d);
    logic [3:0] e_an0, e_an1;
    logic [6:0] e_seg0, e_seg1;
    int dig;
    drive(r, we, d);
    @(posedge clk);
    if (r) begin
      e_an0 = 4'hF; e_seg0 = 7'h7F;
      e_an1 = 4'hF; e_seg1 = 7'h7F;
      m_edges = 0;
      m_value = 16'h0000;
    end else begin
      dig    = (m_edges / DIV) % 4;
      e_an0  = 4'hF & ~(4'(1) << dig);
      e_seg0 = hex_tbl[(m_value >> (4 * dig)) & 16'hF];
      if (dig > 0 && (m_value >> (4 * dig)) == 0) begin
        e_an1 = 4'hF; e_seg1 = 7'h7F;
      end else begin
        e_an1 = e_an0; e_seg1 = e_seg0;
      end
      m_edges++;
      if (we) m_value = d;
    end
    #1;
    chk("an0",  {3'b000, bus0.an}, {3'b000, e_an0});
    chk("seg0", bus0.seg,          e_seg0);
    chk("dp0",  {6'b0, bus0.dp},   7'd1);
    chk("an1",  {3'b000, bus1.an}, {3'b000, e_an1});
    chk("seg1", bus1.seg,          e_seg1);
    chk("dp1",  {6'b0, bus1.dp},   7'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'(($urandom)));
  endtask

  initial begin
    drive(1'b1, 1'b0, 16'h0000);

    // Reset held three cycles, then release: first edge shows digit 0 = "0".
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    chk("first_an",  {3'b000, bus0.an}, 7'b0001110);
    chk("first_seg", bus0.seg, 7'h40);
    idle(3);

    // Full sweep of 12AF.
    step(1'b0, 1'b1, 16'h12AF);
    idle(20);

    // Write 0008 during digit 0, then noise on io_data_in with no strobe.
    while (((m_edges / DIV) % 4) != 0 || (m_edges % DIV) > 1) idle(1);
    step(1'b0, 1'b1, 16'h0008);
    step(1'b0, 1'b0, 16'h0000);
    chk("w0008_seg", bus0.seg, 7'h00);
    idle(16);

    // Leading-zero blanking patterns.
    step(1'b0, 1'b1, 16'h0030);
    idle(16);
    step(1'b0, 1'b1, 16'h0000);
    idle(16);

    // Write on the presc-wrap edge, then reset mid-slot.
    while ((m_edges % DIV) != DIV - 1) idle(1);
    step(1'b0, 1'b1, 16'hBEEF);
    idle(2);
    step(1'b1, 1'b0, 16'h0000);
    chk("midrst_an", {3'b000, bus0.an}, 7'b0001111);
    idle(5);

    // Back-to-back writes.
    step(1'b0, 1'b1, 16'h1111);
    step(1'b0, 1'b1, 16'h2222);
    idle(16);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           (($urandom_range(0, 1) == 0) ? 16'(($urandom_range(0, 255))) : 16'(($urandom))));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
